// File: rtl/discferret_pkg.sv
// Shared definitions for the DiscFerret write path.
//   dw_state_t    : disc_writer FSM states
//   END_OF_STREAM : timing byte that terminates a stream
//   PULSE_FLAG    : bit index in a timing byte requesting a write pulse
//   byte_delay()  : tick delay carried by a timing byte
//   byte_pulse()  : pulse request carried by a timing byte
package discferret_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IDXWAIT,
        ST_FETCH,
        ST_LATCH,
        ST_COUNT,
        ST_PULSE,
        ST_FINISH
    } dw_state_t;

    localparam logic [7:0]  END_OF_STREAM = 8'h00;
    localparam int unsigned PULSE_FLAG    = 7;

    function automatic logic [6:0] byte_delay(input logic [7:0] b);
        return b[6:0];
    endfunction

    function automatic logic byte_pulse(input logic [7:0] b);
        return b[PULSE_FLAG];
    endfunction

endpackage

// File: rtl/dw_pulse_gen.sv
// Fixed-width write pulse generator for disc_writer.
//   clock   : system clock
//   reset   : asynchronous active-low reset
//   clear   : synchronous cancel of any pulse in progress
//   trigger : start a pulse of PULSE_W clocks
//   pulse   : registered pulse output (drive WRITE DATA)
//   busy    : high while the pulse has further cycles after the current one
module dw_pulse_gen #(
    parameter int unsigned PULSE_W = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic trigger,
    output logic pulse,
    output logic busy
);

    localparam int unsigned CW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

    logic [CW-1:0] remain;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pulse  <= 1'b0;
            remain <= '0;
        end else if (clear) begin
            pulse  <= 1'b0;
            remain <= '0;
        end else if (trigger) begin
            pulse  <= 1'b1;
            remain <= CW'(PULSE_W - 1);
        end else if (pulse) begin
            if (remain == '0) begin
                pulse <= 1'b0;
            end else begin
                remain <= remain - 1'b1;
            end
        end
    end

    // Low during the final pulse cycle so the caller can move on gap-free.
    assign busy = pulse && (remain != '0);

endmodule

// File: rtl/disc_writer.sv
// Replays a timing stream from acquisition RAM onto the drive WRITE DATA /
// WRITE GATE lines. Each byte: b[6:0] = tick delay, b[7] = pulse at the end,
// 0x00 = end of stream.
//   clock, reset        : system clock, asynchronous active-low reset
//   tick                : timing-base enable
//   start, abort        : begin at address 0 / stop immediately
//   wait_index, fd_index: optionally wait for an index rising edge first
//   ram_addr, ram_rd    : RAM read port (data on ram_data the next cycle)
//   ram_data            : RAM read data
//   fd_write_gate       : drive WRITE GATE
//   fd_write_data       : drive WRITE DATA (PULSE_W-clock pulses)
//   busy, done          : activity flag / one-cycle normal-completion pulse
module disc_writer
    import discferret_pkg::*;
#(
    parameter int unsigned ADDR_W  = 19,
    parameter int unsigned PULSE_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tick,
    input  logic              start,
    input  logic              abort,
    input  logic              wait_index,
    input  logic              fd_index,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [7:0]        ram_data,
    output logic              fd_write_gate,
    output logic              fd_write_data,
    output logic              busy,
    output logic              done
);

    dw_state_t         state, state_nxt;
    logic [ADDR_W-1:0] ram_addr_nxt;
    logic              ram_rd_nxt;
    logic              gate_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic [6:0]        count, count_nxt;
    logic              pulse_flag, pulse_flag_nxt;
    logic [7:0]        hold, hold_nxt;
    logic              hold_valid, hold_valid_nxt;
    logic              at_end, at_end_nxt;
    logic              rd_d;
    logic              idx_prev;
    logic              pg_trigger;
    logic              pg_clear;
    logic              pg_busy;
    logic              load_held;
    logic              prefetch;
    logic [7:0]        held_byte;

    dw_pulse_gen #(
        .PULSE_W(PULSE_W)
    ) u_pulse (
        .clock  (clock),
        .reset  (reset),
        .clear  (pg_clear),
        .trigger(pg_trigger),
        .pulse  (fd_write_data),
        .busy   (pg_busy)
    );

    always_comb begin
        state_nxt      = state;
        ram_addr_nxt   = ram_addr;
        ram_rd_nxt     = 1'b0;
        gate_nxt       = fd_write_gate;
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        count_nxt      = count;
        pulse_flag_nxt = pulse_flag;
        hold_nxt       = hold;
        hold_valid_nxt = hold_valid;
        at_end_nxt     = at_end;
        pg_trigger     = 1'b0;
        pg_clear       = 1'b0;
        load_held      = 1'b0;
        prefetch       = 1'b0;
        // The prefetched byte may be consumed in the same cycle it arrives.
        held_byte      = hold_valid ? hold : ram_data;

        // ram_addr always points at the next unread byte; a read at the top
        // address means no further byte exists.
        if (ram_rd) begin
            ram_addr_nxt = ram_addr + 1'b1;
            at_end_nxt   = (ram_addr == '1);
        end

        if (rd_d && (state == ST_COUNT || state == ST_PULSE)) begin
            hold_nxt       = ram_data;
            hold_valid_nxt = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (start) begin
                    busy_nxt       = 1'b1;
                    ram_addr_nxt   = '0;
                    at_end_nxt     = 1'b0;
                    hold_valid_nxt = 1'b0;
                    if (wait_index) begin
                        state_nxt = ST_IDXWAIT;
                    end else begin
                        state_nxt  = ST_FETCH;
                        ram_rd_nxt = 1'b1;
                    end
                end
            end
            ST_IDXWAIT: begin
                if (fd_index && !idx_prev) begin
                    state_nxt  = ST_FETCH;
                    ram_rd_nxt = 1'b1;
                end
            end
            ST_FETCH: begin
                state_nxt = ST_LATCH;
            end
            ST_LATCH: begin
                if (ram_data == END_OF_STREAM) begin
                    state_nxt = ST_FINISH;
                end else begin
                    count_nxt      = byte_delay(ram_data);
                    pulse_flag_nxt = byte_pulse(ram_data);
                    gate_nxt       = 1'b1;
                    state_nxt      = ST_COUNT;
                    prefetch       = 1'b1;
                end
            end
            ST_COUNT: begin
                if (tick) begin
                    if (count == '0) begin
                        if (pulse_flag) begin
                            state_nxt  = ST_PULSE;
                            pg_trigger = 1'b1;
                        end else begin
                            load_held = 1'b1;
                        end
                    end else begin
                        count_nxt = count - 7'd1;
                    end
                end
            end
            ST_PULSE: begin
                if (!pg_busy) begin
                    load_held = 1'b1;
                end
            end
            ST_FINISH: begin
                gate_nxt  = 1'b0;
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (load_held) begin
            if (held_byte == END_OF_STREAM) begin
                state_nxt = ST_FINISH;
            end else begin
                count_nxt      = byte_delay(held_byte);
                pulse_flag_nxt = byte_pulse(held_byte);
                state_nxt      = ST_COUNT;
                prefetch       = 1'b1;
            end
        end

        // Past the top address the stream ends as if 0x00 had been read.
        if (prefetch) begin
            if (at_end) begin
                hold_nxt       = END_OF_STREAM;
                hold_valid_nxt = 1'b1;
            end else begin
                ram_rd_nxt     = 1'b1;
                hold_valid_nxt = 1'b0;
            end
        end

        if (abort) begin
            state_nxt  = ST_IDLE;
            gate_nxt   = 1'b0;
            busy_nxt   = 1'b0;
            done_nxt   = 1'b0;
            ram_rd_nxt = 1'b0;
            pg_trigger = 1'b0;
            pg_clear   = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            ram_addr      <= '0;
            ram_rd        <= 1'b0;
            fd_write_gate <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            count         <= '0;
            pulse_flag    <= 1'b0;
            hold          <= '0;
            hold_valid    <= 1'b0;
            at_end        <= 1'b0;
            rd_d          <= 1'b0;
            idx_prev      <= 1'b0;
        end else begin
            state         <= state_nxt;
            ram_addr      <= ram_addr_nxt;
            ram_rd        <= ram_rd_nxt;
            fd_write_gate <= gate_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            count         <= count_nxt;
            pulse_flag    <= pulse_flag_nxt;
            hold          <= hold_nxt;
            hold_valid    <= hold_valid_nxt;
            at_end        <= at_end_nxt;
            rd_d          <= ram_rd;
            idx_prev      <= fd_index;
        end
    end

endmodule

// File: tb/tb_disc_writer.sv
// Self-checking bench for disc_writer: an event-level reference model turns
// the RAM byte list and the tick pattern into expected gate/data/busy/done
// waveforms, compared every clock.
module tb_disc_writer;

    localparam int unsigned AW    = 3;
    localparam int unsigned PW    = 4;
    localparam int          DEPTH = 8;
    localparam int          HMAX  = 4096;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          tick = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          wait_index = 1'b0;
    logic          fd_index = 1'b0;
    logic [AW-1:0] ram_addr;
    logic          ram_rd;
    logic [7:0]    ram_data;
    logic          fd_write_gate;
    logic          fd_write_data;
    logic          busy;
    logic          done;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [DEPTH];
    bit tick_pat [HMAX];
    bit exp_gate [HMAX];
    bit exp_data [HMAX];
    bit exp_busy [HMAX];
    bit exp_done [HMAX];
    int model_exit;
    bit model_ok;

    always #5 clock = ~clock;

    always @(posedge clock) if (ram_rd) ram_data <= mem[ram_addr];

    disc_writer #(
        .ADDR_W (AW),
        .PULSE_W(PW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .tick         (tick),
        .start        (start),
        .abort        (abort),
        .wait_index   (wait_index),
        .fd_index     (fd_index),
        .ram_addr     (ram_addr),
        .ram_rd       (ram_rd),
        .ram_data     (ram_data),
        .fd_write_gate(fd_write_gate),
        .fd_write_data(fd_write_data),
        .busy         (busy),
        .done         (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic gen_ticks(input int pct);
        for (int i = 0; i < HMAX; i++) tick_pat[i] = (int'($urandom_range(99, 0)) < pct);
    endtask

    task automatic fill_random(input int len, input bit terminate);
        logic [7:0] b;
        for (int i = 0; i < DEPTH; i++) begin
            b = {1'($urandom_range(1, 0)), 7'($urandom_range(6, 0))};
            if (b == 8'h00) b = 8'h01;
            mem[i] = b;
        end
        if (terminate) mem[len] = 8'h00;
    endtask

    // Event model: byte with delay N acts on the (N+1)-th tick after it is
    // loaded; a pulse occupies PW clocks, during which ticks do not count.
    task automatic build_model(input int base, input int abort_at);
        int t, idx, need, seen, a, fin;
        for (int e = 0; e < HMAX; e++) begin
            exp_gate[e] = 1'b0; exp_data[e] = 1'b0;
            exp_busy[e] = 1'b0; exp_done[e] = 1'b0;
        end
        model_ok = 1'b1;
        idx = 0;
        t = base + 2;
        fin = -1;
        if (mem[0] == 8'h00) begin
            fin = base + 2;
        end else begin
            while (fin < 0) begin
                if (mem[idx] == 8'h00) begin
                    fin = t;
                end else begin
                    need = int'(mem[idx][6:0]) + 1;
                    seen = 0;
                    a = t;
                    while (seen < need && a < HMAX - 64) begin
                        a++;
                        if (tick_pat[a]) seen++;
                    end
                    if (seen < need) begin
                        model_ok = 1'b0;
                        fin = a;
                    end else begin
                        if (mem[idx][7]) begin
                            for (int k = 0; k < int'(PW); k++) exp_data[a + k] = 1'b1;
                            t = a + int'(PW);
                        end else begin
                            t = a;
                        end
                        idx++;
                        if (idx == DEPTH) fin = t;
                    end
                end
            end
            for (int e = base + 2; e <= fin; e++) exp_gate[e] = 1'b1;
        end
        model_exit = fin + 1;
        for (int e = 0; e < model_exit; e++) exp_busy[e] = 1'b1;
        exp_done[model_exit] = 1'b1;
        if (abort_at >= 0) begin
            for (int e = abort_at; e < HMAX; e++) begin
                exp_gate[e] = 1'b0; exp_data[e] = 1'b0;
                exp_busy[e] = 1'b0; exp_done[e] = 1'b0;
            end
        end
        if (!model_ok) begin
            $display("FAIL model_horizon: stream does not end within %0d cycles", HMAX);
            $fatal(1, "reference model horizon exceeded");
        end
    endtask

    // Edge 0 samples start; outputs are compared #1 after every edge.
    task automatic run_stream(input string tag, input bit widx, input int idx_edge,
                              input int abort_at, input int extra_start);
        int base, last;
        base = widx ? idx_edge : 0;
        build_model(base, abort_at);
        last = (abort_at >= 0) ? abort_at + 30 : model_exit + 3;
        wait_index = widx;
        fd_index = 1'b0;
        start = 1'b1;
        abort = 1'b0;
        tick = tick_pat[0];
        for (int e = 0; e <= last; e++) begin
            @(posedge clock);
            #1;
            start    = ((e + 1) == extra_start);
            abort    = ((e + 1) == abort_at);
            tick     = tick_pat[e + 1];
            fd_index = widx && ((e + 1) >= idx_edge);
            if (e == 0) begin
                check({tag, ".addr0"}, 32'(ram_addr), 32'd0);
                check({tag, ".rd0"}, 32'(ram_rd), 32'(!widx));
            end
            check($sformatf("%s.gate@%0d", tag, e), 32'(fd_write_gate), 32'(exp_gate[e]));
            check($sformatf("%s.wdata@%0d", tag, e), 32'(fd_write_data), 32'(exp_data[e]));
            check($sformatf("%s.busy@%0d", tag, e), 32'(busy), 32'(exp_busy[e]));
            check($sformatf("%s.done@%0d", tag, e), 32'(done), 32'(exp_done[e]));
        end
        start = 1'b0; abort = 1'b0; tick = 1'b0; fd_index = 1'b0; wait_index = 1'b0;
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        #3 reset = 1'b0;
        #1;
        check("rst.gate", 32'(fd_write_gate), 32'd0);
        check("rst.wdata", 32'(fd_write_data), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.rd", 32'(ram_rd), 32'd0);
        check("rst.addr", 32'(ram_addr), 32'd0);
        @(negedge clock) reset = 1'b1;
        @(posedge clock);
        #1;

        // Directed stream, tick every clock; a second start mid-run is ignored.
        fill_random(3, 1'b1);
        mem[0] = 8'h83; mem[1] = 8'h02; mem[2] = 8'h81; mem[3] = 8'h00;
        gen_ticks(100);
        run_stream("t2", 1'b0, 0, -1, 10);

        // Zero-delay pulses back to back.
        fill_random(2, 1'b1);
        mem[0] = 8'h80; mem[1] = 8'h80; mem[2] = 8'h00;
        run_stream("t3", 1'b0, 0, -1, -1);

        // Empty stream: gate never rises, done still pulses.
        mem[0] = 8'h00;
        run_stream("empty", 1'b0, 0, -1, -1);

        // Wait for an index edge 500 clocks after start.
        fill_random(5, 1'b1);
        gen_ticks(50);
        run_stream("t4", 1'b1, 500, -1, -1);

        // Abort inside a long 0xFF count, then a fresh run from address 0.
        fill_random(3, 1'b1);
        mem[0] = 8'hFF;
        gen_ticks(100);
        run_stream("t5", 1'b0, 0, 40, 25);
        fill_random(4, 1'b1);
        gen_ticks(70);
        run_stream("t5r", 1'b0, 0, -1, -1);

        // Abort while a pulse is being written.
        fill_random(3, 1'b1);
        mem[0] = 8'h80; mem[1] = 8'h80;
        gen_ticks(100);
        run_stream("abp", 1'b0, 0, 5, -1);

        // No terminator: stream ends after the top address.
        fill_random(DEPTH, 1'b0);
        gen_ticks(60);
        run_stream("t6", 1'b0, 0, -1, -1);

        // start and abort together: nothing starts.
        start = 1'b1; abort = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0; abort = 1'b0;
        check("sa.busy", 32'(busy), 32'd0);
        check("sa.rd", 32'(ram_rd), 32'd0);
        repeat (3) @(posedge clock);
        #1;
        check("sa.busy_late", 32'(busy), 32'd0);
        check("sa.gate_late", 32'(fd_write_gate), 32'd0);

        for (int r = 0; r < 6; r++) begin
            fill_random(int'($urandom_range(7, 1)), 1'b1);
            gen_ticks(int'($urandom_range(100, 30)));
            run_stream($sformatf("rnd%0d", r), 1'b0, 0, -1, -1);
        end

        // Asynchronous reset while a pulse is on the line.
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h80;
        start = 1'b1; tick = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clock);
        #1;
        check("rmid.pre_wdata", 32'(fd_write_data), 32'd1);
        check("rmid.pre_gate", 32'(fd_write_gate), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("rmid.gate", 32'(fd_write_gate), 32'd0);
        check("rmid.wdata", 32'(fd_write_data), 32'd0);
        check("rmid.busy", 32'(busy), 32'd0);
        check("rmid.rd", 32'(ram_rd), 32'd0);
        check("rmid.addr", 32'(ram_addr), 32'd0);
        @(negedge clock) reset = 1'b1;
        tick = 1'b0;
        @(posedge clock);
        #1;
        check("rmid.idle_busy", 32'(busy), 32'd0);
        check("rmid.idle_done", 32'(done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
